// File: rtl/sram_bus_pkg.sv
// sram_bus_pkg: shared widths, BLE bit position and FSM state encoding for the SRAM bus target
package sram_bus_pkg;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int BLE_BIT = 15;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ALO,
    S_AHI,
    S_DATA,
    S_MEM,
    S_DRIVE,
    S_DONE
  } state_e;
endpackage

// File: rtl/sram_addr_latch.sv
// sram_addr_latch: two-phase muxed address capture and decode-hit compare
module sram_addr_latch
  import sram_bus_pkg::*;
#(
  parameter logic [AW-1:0] BASE = 32'h0000_0000,
  parameter logic [AW-1:0] MASK = 32'hFFFF_0000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cap_lo,
  input  logic          cap_hi,
  input  logic          bhe,
  input  logic [DW-1:0] bus_in,
  output logic [AW-1:1] addr,
  output logic          ble,
  output logic          hit
);
  logic [DW-1:0]        lo_q, lo_d;
  logic [BLE_BIT-1:0]   hi_q, hi_d;
  logic                 ble_q, ble_d;
  logic [AW-1:0]        cand_addr;
  // Low phase loads addr[16:1]; high phase loads addr[31:17] and the byte-low-enable bit
  always_comb begin
    lo_d  = cap_lo ? bus_in : lo_q;
    hi_d  = cap_hi ? bus_in[BLE_BIT-1:0] : hi_q;
    ble_d = cap_hi ? bus_in[BLE_BIT] : ble_q;
  end
  // Address phase registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lo_q  <= '0;
      hi_q  <= '0;
      ble_q <= 1'b0;
    end else begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      ble_q <= ble_d;
    end
  end
  assign addr      = {hi_q, lo_q};
  assign ble       = ble_q;
  assign cand_addr = {hi_q, lo_q, bhe & ~ble_q};
  assign hit       = ((cand_addr ^ BASE) & MASK) == '0;
endmodule

// File: rtl/sram_bus_target.sv
// sram_bus_target: muxed-bus SRAM target bridging to a local valid/ready port (optional SRAM_TGT_TIMEOUT_EN watchdog)
module sram_bus_target
  import sram_bus_pkg::*;
#(
  parameter logic [AW-1:0] BASE = 32'h0000_0000,
  parameter logic [AW-1:0] MASK = 32'hFFFF_0000
`ifdef SRAM_TGT_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ale0,
  input  logic          ale1,
  input  logic          we,
  input  logic          oe,
  input  logic          bhe,
  input  logic [DW-1:0] bus_in,
  output logic [DW-1:0] bus_out,
  output logic          bus_drv,
  output logic          mem_valid,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_be,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);
  state_e        state_q, state_d;
  logic          rw_q, rw_d, valid_q, valid_d, drv_q, drv_d, err_q, err_d, abort_q, abort_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]    be_q, be_d;
  logic [AW-1:1] lat_addr;
  logic          ble, hit, cap_lo, cap_hi;
`ifdef SRAM_TGT_TIMEOUT_EN
  logic [15:0]   cnt_q, cnt_d;
`endif
  assign cap_lo = ale0 && (state_q == S_IDLE || state_q == S_ALO || state_q == S_AHI);
  assign cap_hi = state_q == S_ALO && !ale0 && ale1;
  sram_addr_latch #(.BASE(BASE), .MASK(MASK)) u_latch (
    .clk    (clk),
    .rstn   (rstn),
    .cap_lo (cap_lo),
    .cap_hi (cap_hi),
    .bhe    (bhe),
    .bus_in (bus_in),
    .addr   (lat_addr),
    .ble    (ble),
    .hit    (hit)
  );
  // Next-state and registered-output logic for the bus transaction sequencer
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    valid_d = valid_q;
    drv_d   = drv_q;
    err_d   = err_q;
    abort_d = abort_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    case (state_q)
      S_IDLE: state_d = ale0 ? S_ALO : S_IDLE;
      S_ALO:  state_d = ale0 ? S_ALO : (ale1 ? S_AHI : S_ALO);
      S_AHI: begin
        if (ale0) state_d = S_ALO;
        else if (we && oe) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (we || oe) begin
          rw_d    = we;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        addr_d  = {lat_addr, bhe & ~ble};
        be_d    = rw_q ? {bhe, ble} : 2'b11;
        wdata_d = rw_q ? bus_in : wdata_q;
        abort_d = 1'b0;
        valid_d = hit && be_d != 2'b00;
        state_d = valid_d ? S_MEM : S_DONE;
      end
      S_MEM: begin
        if (!rw_q && !oe && !abort_q) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
        end
        if (mem_ready) begin
          valid_d = 1'b0;
          rdata_d = rw_q ? rdata_q : mem_rdata;
          drv_d   = !rw_q && oe && !abort_q;
          state_d = drv_d ? S_DRIVE : S_DONE;
        end
      end
      S_DRIVE: begin
        if (!oe || we) begin
          drv_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = (!we && !oe) ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
`ifdef SRAM_TGT_TIMEOUT_EN
    if (state_q != S_IDLE && cnt_q == 16'(TIMEOUT - 1)) begin
      err_d   = 1'b1;
      valid_d = 1'b0;
      drv_d   = 1'b0;
      state_d = S_IDLE;
    end
    cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
`endif
  end
  // State and output registers; reset abandons any local access in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
      drv_q   <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      valid_q <= valid_d;
      drv_q   <= drv_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
    end
  end
`ifdef SRAM_TGT_TIMEOUT_EN
  // Per-state dwell counter for the watchdog
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
  assign bus_drv   = drv_q & oe & ~we;
  assign bus_out   = rdata_q;
  assign mem_valid = valid_q;
  assign mem_rw    = rw_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign err       = err_q;
endmodule

// File: tb/tb_sram_bus_target.sv
// tb_sram_bus_target: directed self-checking bench with a transaction-level model of the SRAM bus target
module tb_sram_bus_target;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_0000;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        ale0 = 1'b0, ale1 = 1'b0, we = 1'b0, oe = 1'b0, bhe = 1'b0, mem_ready = 1'b0;
  logic [15:0] bus_in = '0, mem_rdata = '0;
  logic [15:0] bus_out, mem_wdata;
  logic        bus_drv, mem_valid, mem_rw, err;
  logic [31:0] mem_addr;
  logic [1:0]  mem_be;
  int          checks = 0, fails = 0;
  logic [31:0] exp_addr = '0, last_addr = '0;
  logic [1:0]  exp_be = '0, last_be = '0;
  logic [15:0] exp_wdata = '0, exp_rdata = '0, last_wdata = '0;
  logic        exp_rw = 1'b0;
  int          hs = 0, ready_delay = 0, wcnt = 0;
  bit          saw_drv = 1'b0;

  sram_bus_target #(.BASE(BASE), .MASK(MASK)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ale0      (ale0),
    .ale1      (ale1),
    .we        (we),
    .oe        (oe),
    .bhe       (bhe),
    .bus_in    (bus_in),
    .bus_out   (bus_out),
    .bus_drv   (bus_drv),
    .mem_valid (mem_valid),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit exp_access();
    return ((exp_addr ^ BASE) & MASK) == 32'h0 && exp_be != 2'b00;
  endfunction

  initial forever begin
    @(negedge clk);
    if (rstn) begin
      chk("drv_guard", {31'b0, bus_drv & (~oe | we)}, 32'h0);
      if (mem_valid) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", {30'b0, mem_be}, {30'b0, exp_be});
        chk("mem_rw", {31'b0, mem_rw}, {31'b0, exp_rw});
        if (exp_rw) chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, exp_wdata});
      end
      if (bus_drv) begin
        saw_drv = 1'b1;
        chk("bus_out", {16'b0, bus_out}, {16'b0, exp_rdata});
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mem_valid && !mem_ready) begin
      if (wcnt >= ready_delay) mem_ready = 1'b1;
      else wcnt++;
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  initial forever begin
    @(posedge clk);
    if (mem_valid && mem_ready) begin
      hs++;
      last_addr  = mem_addr;
      last_be    = mem_be;
      last_wdata = mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic set_model(input logic [15:0] lo, input logic [15:0] hi, input logic b, input logic rw, input logic [15:0] d);
    exp_addr  = {hi[14:0], lo, b & ~hi[15]};
    exp_be    = rw ? {b, hi[15]} : 2'b11;
    exp_wdata = d;
    exp_rw    = rw;
    hs        = 0;
    saw_drv   = 1'b0;
  endtask

  task automatic addr_phase(input logic [15:0] lo, input logic [15:0] hi);
    @(posedge clk); #1 ale0 = 1'b1; bus_in = lo;
    @(posedge clk); #1 ale0 = 1'b0; ale1 = 1'b1; bus_in = hi;
    @(posedge clk); #1 ale1 = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] lo, input logic [15:0] hi, input logic b, input logic [15:0] d);
    set_model(lo, hi, b, 1'b1, d);
    addr_phase(lo, hi);
    we = 1'b1; bhe = b; bus_in = d;
    repeat (10) @(posedge clk);
    #1 we = 1'b0; bhe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("wr_handshakes", hs, exp_access() ? 1 : 0);
  endtask

  task automatic do_read(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] rd, input int dly, input int oe_cyc, input int tail);
    set_model(lo, hi, 1'b0, 1'b0, 16'h0);
    exp_rdata = rd; mem_rdata = rd; ready_delay = dly;
    addr_phase(lo, hi);
    oe = 1'b1;
    repeat (oe_cyc) @(posedge clk);
    #1 oe = 1'b0;
    repeat (tail) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_mem_valid"}, {31'b0, mem_valid}, 32'h0);
    chk({tag, "_mem_rw"}, {31'b0, mem_rw}, 32'h0);
    chk({tag, "_bus_drv"}, {31'b0, bus_drv}, 32'h0);
    chk({tag, "_err"}, {31'b0, err}, 32'h0);
    chk({tag, "_bus_out"}, {16'b0, bus_out}, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, {16'b0, mem_wdata}, 32'h0);
    chk({tag, "_mem_be"}, {30'b0, mem_be}, 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_values("rst");
    @(posedge clk); #1 rstn = 1'b1;
    ready_delay = 0;
    do_write(16'h091A, 16'h8000, 1'b0, 16'hBEEF);
    chk("w1_addr", last_addr, 32'h0000_1234);
    chk("w1_be", {30'b0, last_be}, 32'h1);
    chk("w1_wdata", {16'b0, last_wdata}, 32'hBEEF);
    chk("w1_err", {31'b0, err}, 32'h0);
    do_write(16'h091A, 16'h0000, 1'b1, 16'h1122);
    chk("w2_addr", last_addr, 32'h0000_1235);
    chk("w2_be", {30'b0, last_be}, 32'h2);
    do_write(16'h0100, 16'h0000, 1'b0, 16'h3333);
    chk("w3_no_access", hs, 0);
    do_read(16'h0020, 16'h0000, 16'hA55A, 2, 10, 3);
    chk("r1_hs", hs, 1);
    chk("r1_drove", {31'b0, saw_drv}, 32'h1);
    chk("r1_addr", last_addr, 32'h0000_0040);
    chk("r1_drv_off", {31'b0, bus_drv}, 32'h0);
    chk("r1_bus_out", {16'b0, bus_out}, 32'hA55A);
    do_read(16'h8000, 16'h0000, 16'h1111, 0, 8, 3);
    chk("miss_hs", hs, 0);
    chk("miss_drove", {31'b0, saw_drv}, 32'h0);
    chk("miss_err", {31'b0, err}, 32'h0);
    do_read(16'h0030, 16'h0000, 16'h5AA5, 6, 3, 12);
    chk("oe_drop_hs", hs, 1);
    chk("oe_drop_drove", {31'b0, saw_drv}, 32'h0);
    chk("oe_drop_err", {31'b0, err}, 32'h1);
    set_model(16'h0050, 16'h0000, 1'b0, 1'b0, 16'h0);
    ready_delay = 1000;
    addr_phase(16'h0050, 16'h0000);
    oe = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("mid_mem_valid", {31'b0, mem_valid}, 32'h1);
    #2 rstn = 1'b0;
    #1 chk_reset_values("mid_rst");
    oe = 1'b0; ready_delay = 1;
    @(posedge clk); #1 rstn = 1'b1;
    do_write(16'h2000, 16'h0000, 1'b1, 16'h0F0F);
    chk("post_rst_addr", last_addr, 32'h0000_4001);
    chk("post_rst_err", {31'b0, err}, 32'h0);
    set_model(16'h0010, 16'h0000, 1'b0, 1'b1, 16'h0);
    addr_phase(16'h0010, 16'h0000);
    we = 1'b1; oe = 1'b1;
    repeat (3) @(posedge clk);
    #1 we = 1'b0; oe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("both_err", {31'b0, err}, 32'h1);
    chk("both_hs", hs, 0);
    @(posedge clk); #1 ale0 = 1'b1; bus_in = 16'h7777;
    do_write(16'h0020, 16'h8000, 1'b0, 16'hCAFE);
    chk("restart_addr", last_addr, 32'h0000_0040);
    chk("restart_wdata", {16'b0, last_wdata}, 32'hCAFE);
`ifdef SRAM_TGT_TIMEOUT_EN
    #2 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    ale0 = 1'b1; bus_in = 16'h0001;
    @(posedge clk); #1 ale0 = 1'b0;
    repeat (15) @(posedge clk);
    #1 chk("tmo_before", {31'b0, err}, 32'h0);
    @(posedge clk); #1 chk("tmo_err", {31'b0, err}, 32'h1);
    ready_delay = 0;
    do_write(16'h0008, 16'h8000, 1'b0, 16'h1357);
    chk("tmo_idle_addr", last_addr, 32'h0000_0010);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/sram_bus_target.md
SRAM_BUS_TARGET -- requirements
Module: sram_bus_target

Interface
REQ-001 Parameters: BASE, 32'h0000_0000, decode base address; MASK, 32'hFFFF_0000, address bits compared against BASE; TIMEOUT, 16, max cycles in any non-IDLE state (only with SRAM_TGT_TIMEOUT_EN).
REQ-002 Ports: clk  in  1  single clock, all logic on posedge; rstn  in  1  asynchronous active-low reset.
REQ-003 Bus ports: ale0 in 1 low-address phase; ale1 in 1 high-address phase; we in 1 write strobe; oe in 1 read strobe; bhe in 1 high-byte enable; bus_in in 16 muxed address/data from initiator.
REQ-004 Bus outputs: bus_out out 16 read data; bus_drv out 1 target drives bus (active high).
REQ-005 Local ports: mem_valid out 1; mem_rw out 1 (1=write); mem_addr out 32; mem_wdata out 16; mem_be out 2 ({high,low}); mem_ready in 1; mem_rdata in 16; err out 1 (sticky).

Function
REQ-006 States: IDLE, ALO, AHI, DATA, MEM, DRIVE, DONE; all transitions on posedge clk.
REQ-007 IDLE: ale0 sampled 1 -> capture bus_in as addr[16:1], go ALO.
REQ-008 ALO: ale1 sampled 1 -> capture bus_in[14:0] as addr[31:17], bus_in[15] as ble, go AHI; ale1 0 -> stay.
REQ-009 AHI: we=1 -> write; oe=1 -> read; go DATA; neither -> stay; both 1 -> set err, go IDLE.
REQ-010 mem_addr = {addr[31:1], bhe & !ble}; decode hit = ((mem_addr ^ BASE) & MASK) == 0.
REQ-011 DATA write: capture bus_in as wdata and bhe; mem_be = {bhe, ble}; if hit and mem_be != 0 go MEM, else go DONE with no local access.
REQ-012 DATA read: if hit go MEM with mem_be=2'b11, else go DONE; bus_drv stays 0 on miss.
REQ-013 MEM: mem_valid=1 with mem_rw/addr/wdata/be held stable until mem_ready=1; mem_valid drops the following cycle; read latches mem_rdata into bus_out.
REQ-014 After MEM: read -> DRIVE, bus_drv=1 while oe=1; write -> DONE.
REQ-015 DRIVE: oe sampled 0 -> bus_drv=0 same edge, go DONE; bus_drv SHALL never be 1 while oe=0 or we=1.
REQ-016 oe falls while in MEM (read): set err, abandon bus drive, finish local access, go DONE.
REQ-017 DONE: go IDLE once we=0 and oe=0; ale0=1 in DONE is ignored.
REQ-018 ale0=1 in ALO/AHI restarts: recapture addr[16:1], go ALO.
REQ-019 err set only by REQ-009, REQ-016, REQ-024; cleared only by reset.

Reset
REQ-020 rstn low: state IDLE; mem_valid, mem_rw, bus_drv, err = 0; bus_out, mem_addr, mem_wdata = 0; mem_be = 2'b00.
REQ-021 Reset mid-MEM drops mem_valid immediately; no local-side completion expected.
REQ-022 Release: first posedge with rstn=1 samples normally.

Configuration
REQ-023 Macro SRAM_TGT_TIMEOUT_EN compiles in a per-state cycle counter, cleared on each state change.
REQ-024 With it: counter reaching TIMEOUT in any non-IDLE state -> err=1, mem_valid=0, bus_drv=0, go IDLE. Without it: no counter, states wait indefinitely.

Structure
REQ-025 Shared package sram_bus_pkg: state enum, bus width 16, address width 32, BLE bit position 15.
REQ-026 Sub-module sram_addr_latch: two-phase address capture and decode-hit compare.

Verification
REQ-027 Write 0x0000_1234 (low byte), data 0xBEEF: ALO 0x091A, AHI 0x8000 -> mem_addr 0x0000_1234, mem_be 2'b01, mem_wdata 0xBEEF, one mem_valid handshake.
REQ-028 Read 0x0000_0040, mem_ready after 2 cycles, rdata 0xA55A -> bus_drv=1 with bus_out 0xA55A until oe falls, then 0.
REQ-029 Read at 0x0001_0000 with BASE 0, MASK 0xFFFF_0000 -> miss: no mem_valid, bus_drv 0, return to IDLE.
REQ-030 oe drops while mem_ready held 0 -> err=1, bus_drv never asserts, returns to IDLE after mem_ready.
REQ-031 rstn low during MEM -> all outputs at reset values same cycle; subsequent write completes normally.
REQ-032 SRAM_TGT_TIMEOUT_EN, TIMEOUT 16: ale0 then no ale1 -> err=1 after 16 cycles in ALO, state IDLE.
